serial_adder: RTL and testbench

Parametrised multi-cycle adder/subtractor that extends the combinational half-adder cell into a sequential, digit-serial datapath. It latches two WIDTH-bit operands on a start handshake. It then adds DIGIT bits per cycle, LSB first, with a registered carry between digits. It presents a registered sum, carry-out and signed-overflow flag with a one-cycle done pulse. It is the area-lean arithmetic building block for slow control paths where a full-width adder is not justified.

---
 rtl/serial_adder.sv | 104 ++++++++++
 tb/tb_serial_adder.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder: digit-serial adder/subtractor. Operands are latched on start,
// then DIGIT bits are summed per cycle, LSB first. A registered carry links
// each digit to the next. The result, carry-out and signed overflow appear
// together with a one-cycle done pulse after WIDTH/DIGIT cycles in RUN.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Reject parameter sets where the digit does not tile the word exactly.
  generate
    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("serial_adder: WIDTH must be >= 2 and an exact multiple of DIGIT");
    end
  endgenerate

  logic [1:0]       state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] part;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [DIGIT:0]   slice;
  logic [WIDTH-1:0] part_next;
  logic             slice_ovf;

  // One digit of addition plus the partial result with that digit shifted in
  // at the top. Overflow is derived from the slice's top bit: equal operand
  // signs with a different result sign is the same as carry-in XOR carry-out.
  always_comb begin
    slice     = {1'b0, opa[DIGIT-1:0]} + {1'b0, opb[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
    part_next = WIDTH'({slice[DIGIT-1:0], part} >> DIGIT);
    slice_ovf = (opa[DIGIT-1] == opb[DIGIT-1]) && (slice[DIGIT-1] != opa[DIGIT-1]);
  end

  // Control FSM and datapath. Subtraction is a + ~b + 1, so b is inverted at
  // load time and the initial carry is set to sub. A start in IDLE or DONE
  // loads a new operation; a start while in RUN is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      opa       <= '0;
      opb       <= '0;
      part      <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
    end else begin
      done <= 1'b0;
      if (state == RUN) begin
        opa   <= opa >> DIGIT;
        opb   <= opb >> DIGIT;
        part  <= part_next;
        carry <= slice[DIGIT];
        cnt   <= cnt + 1'b1;
        if (cnt == LAST) begin
          state     <= DONE;
          busy      <= 1'b0;
          done      <= 1'b1;
          sum       <= part_next;
          carry_out <= slice[DIGIT];
          overflow  <= slice_ovf;
        end
      end else if (start) begin
        state <= RUN;
        busy  <= 1'b1;
        opa   <= a;
        opb   <= b ^ {WIDTH{sub}};
        carry <= sub;
        cnt   <= '0;
        part  <= '0;
      end else begin
        state <= IDLE;
        busy  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench for serial_adder. An 8-bit/1-bit-digit
// instance runs the directed cases, and a 4-bit/2-bit-digit instance is swept
// over every operand pair in both modes.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst8, start8, sub8;
  logic [7:0] a8, b8, sum8;
  logic       busy8, done8, cout8, ovf8;

  logic       rst4, start4, sub4;
  logic [3:0] a4, b4, sum4;
  logic       busy4, done4, cout4, ovf4;

  int tests_run = 0;
  int tests_failed = 0;

  logic [9:0] q8[$];
  logic [9:0] q4[$];

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_wide (
    .clk(clk), .rst_n(rst8), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .carry_out(cout8), .overflow(ovf8)
  );

  serial_adder #(.WIDTH(4), .DIGIT(2)) u_narrow (
    .clk(clk), .rst_n(rst4), .start(start4), .sub(sub4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .sum(sum4), .carry_out(cout4), .overflow(ovf4)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference result packed as {overflow, carry_out, sum[7:0]} for width w.
  function automatic logic [9:0] refModel(input int w, input int av, input int bv, input bit s);
    int  mask;
    int  r;
    bit  c, o, sa, sb, sr;
    mask = (1 << w) - 1;
    if (s) begin
      r = (av - bv) & mask;
      c = (av >= bv);
    end else begin
      r = (av + bv) & mask;
      c = ((av + bv) > mask);
    end
    sa = bit'((av >> (w - 1)) & 1);
    sb = bit'((bv >> (w - 1)) & 1);
    sr = bit'((r >> (w - 1)) & 1);
    if (s) o = (sa != sb) && (sr != sa);
    else   o = (sa == sb) && (sr != sa);
    return {o, c, r[7:0]};
  endfunction

  // Drive one start on the wide instance; keep=1 records the expected result.
  task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, input logic s, input bit keep);
    a8 = av;
    b8 = bv;
    sub8 = s;
    start8 = 1'b1;
    if (keep) q8.push_back(refModel(8, int'(av), int'(bv), s));
    @(posedge clk);
    #1;
    start8 = 1'b0;
  endtask

  task automatic applyStimulusNarrow(input logic [3:0] av, input logic [3:0] bv, input logic s);
    a4 = av;
    b4 = bv;
    sub4 = s;
    start4 = 1'b1;
    q4.push_back(refModel(4, int'(av), int'(bv), s));
    @(posedge clk);
    #1;
    start4 = 1'b0;
  endtask

  // Count negedges with done low until done is seen, bounded.
  task automatic waitDone8(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done8) break;
      n++;
    end
    checkOutput("done8_seen", 32'(done8), 32'd1);
  endtask

  task automatic waitDone4(output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done4) break;
      n++;
    end
    checkOutput("done4_seen", 32'(done4), 32'd1);
  endtask

  // Wide-instance monitor: busy run length, single-cycle done, scoreboard pop.
  initial begin
    int run = 0;
    logic prev_busy = 1'b0;
    logic prev_done = 1'b0;
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (!rst8) begin
        run = 0;
        prev_busy = 1'b0;
        prev_done = 1'b0;
      end else begin
        if (busy8) run++;
        else if (prev_busy) begin
          checkOutput("busy8_len", 32'(run), 32'd8);
          run = 0;
        end
        if (done8) begin
          checkOutput("done8_single", 32'(prev_done), 32'd0);
          checkOutput("done8_expected", 32'(q8.size() > 0), 32'd1);
          if (q8.size() > 0) begin
            e = q8.pop_front();
            checkOutput("sum8", 32'(sum8), 32'(e[7:0]));
            checkOutput("cout8", 32'(cout8), 32'(e[8]));
            checkOutput("ovf8", 32'(ovf8), 32'(e[9]));
          end
        end
        prev_busy = busy8;
        prev_done = done8;
      end
    end
  end

  // Narrow-instance monitor, same checks with a two-cycle busy window.
  initial begin
    int run = 0;
    logic prev_busy = 1'b0;
    logic prev_done = 1'b0;
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (!rst4) begin
        run = 0;
        prev_busy = 1'b0;
        prev_done = 1'b0;
      end else begin
        if (busy4) run++;
        else if (prev_busy) begin
          checkOutput("busy4_len", 32'(run), 32'd2);
          run = 0;
        end
        if (done4) begin
          checkOutput("done4_single", 32'(prev_done), 32'd0);
          checkOutput("done4_expected", 32'(q4.size() > 0), 32'd1);
          if (q4.size() > 0) begin
            e = q4.pop_front();
            checkOutput("sum4", 32'(sum4), 32'(e[3:0]));
            checkOutput("cout4", 32'(cout4), 32'(e[8]));
            checkOutput("ovf4", 32'(ovf4), 32'(e[9]));
          end
        end
        prev_busy = busy4;
        prev_done = done4;
      end
    end
  end

  // Hard stop in case something wedges outside the bounded waits.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence on the wide instance, then the narrow sweep.
  initial begin
    int n;
    rst8 = 1'b0; start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
    rst4 = 1'b0; start4 = 1'b0; sub4 = 1'b0; a4 = '0; b4 = '0;
    #3;
    checkOutput("rst_busy", 32'(busy8), 32'd0);
    checkOutput("rst_done", 32'(done8), 32'd0);
    checkOutput("rst_sum", 32'(sum8), 32'd0);
    checkOutput("rst_cout", 32'(cout8), 32'd0);
    checkOutput("rst_ovf", 32'(ovf8), 32'd0);
    checkOutput("rst4_sum", 32'(sum4), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst8 = 1'b1;
    rst4 = 1'b1;
    @(posedge clk);
    #1;

    // Plain add; done appears in the cycle after the 8th edge past start.
    applyStimulus(8'h0F, 8'h01, 1'b0, 1'b1);
    checkOutput("busy_after_start", 32'(busy8), 32'd1);
    waitDone8(n);
    checkOutput("latency8", 32'(n), 32'd8);

    // Carry-out, then a back-to-back start issued in the DONE cycle.
    @(posedge clk); #1;
    applyStimulus(8'hFF, 8'h01, 1'b0, 1'b1);
    waitDone8(n);
    applyStimulus(8'h7F, 8'h01, 1'b0, 1'b1);
    checkOutput("b2b_busy", 32'(busy8), 32'd1);
    waitDone8(n);
    checkOutput("b2b_latency8", 32'(n), 32'd8);

    // Subtraction with borrow, then without borrow but with overflow.
    @(posedge clk); #1;
    applyStimulus(8'h05, 8'h07, 1'b1, 1'b1);
    waitDone8(n);
    applyStimulus(8'h80, 8'h01, 1'b1, 1'b1);
    waitDone8(n);

    // Start and operand changes during RUN must be ignored.
    @(posedge clk); #1;
    applyStimulus(8'h10, 8'h20, 1'b0, 1'b1);
    @(posedge clk);
    @(posedge clk); #1;
    a8 = 8'hAA; b8 = 8'h55; sub8 = 1'b1; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'h00; b8 = 8'hFF;
    checkOutput("midrun_busy", 32'(busy8), 32'd1);
    waitDone8(n);
    repeat (3) @(negedge clk);
    checkOutput("no_second_done", 32'(q8.size()), 32'd0);

    // Asynchronous reset in the 4th RUN cycle aborts the operation.
    @(posedge clk); #1;
    applyStimulus(8'h33, 8'h44, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    checkOutput("pre_abort_sum", 32'(sum8), 32'h30);
    rst8 = 1'b0;
    #1;
    checkOutput("abort_busy", 32'(busy8), 32'd0);
    checkOutput("abort_done", 32'(done8), 32'd0);
    checkOutput("abort_sum", 32'(sum8), 32'd0);
    checkOutput("abort_cout", 32'(cout8), 32'd0);
    checkOutput("abort_ovf", 32'(ovf8), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst8 = 1'b1;
    repeat (12) @(negedge clk);
    checkOutput("abort_no_done", 32'(done8), 32'd0);
    @(posedge clk); #1;
    applyStimulus(8'h01, 8'h02, 1'b0, 1'b1);
    waitDone8(n);
    checkOutput("post_reset_latency8", 32'(n), 32'd8);

    // Exhaustive narrow sweep, every op started in the previous DONE cycle.
    for (int s = 0; s < 2; s++) begin
      for (int av = 0; av < 16; av++) begin
        for (int bv = 0; bv < 16; bv++) begin
          applyStimulusNarrow(4'(av), 4'(bv), 1'(s));
          waitDone4(n);
          checkOutput("latency4", 32'(n), 32'd2);
        end
      end
    end

    repeat (4) @(negedge clk);
    checkOutput("sb8_drained", 32'(q8.size()), 32'd0);
    checkOutput("sb4_drained", 32'(q4.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
